// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer
// Serialises a halted-pipeline debug snapshot into the UART transmit FIFO:
// header, four inter-stage latches, register file, a data-memory window and a
// trailer, one word per accepted FIFO slot. Owns the FIFO write side while busy.

module debug_dump_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int MEM_WORDS  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [63:0]           i_IF_ID_latch,
  input  logic [138:0]          i_ID_EX_latch,
  input  logic [75:0]           i_EX_MEM_latch,
  input  logic [70:0]           i_MEM_WB_latch,
  output logic [4:0]            o_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_reg_content,
  output logic [31:0]           o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_content,
  output logic                  o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  input  logic                  i_fifo_full,
  output logic                  o_busy,
  output logic                  o_done
);

  // Latch widths and the number of FIFO words each one occupies.
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 139;
  localparam int EX_MEM_W = 76;
  localparam int MEM_WB_W = 71;

  localparam int IF_ID_N  = (IF_ID_W  + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int ID_EX_N  = (ID_EX_W  + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int EX_MEM_N = (EX_MEM_W + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int MEM_WB_N = (MEM_WB_W + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int LATCH_N  = IF_ID_N + ID_EX_N + EX_MEM_N + MEM_WB_N;

  localparam int IF_ID_PW  = IF_ID_N  * DATA_WIDTH;
  localparam int ID_EX_PW  = ID_EX_N  * DATA_WIDTH;
  localparam int EX_MEM_PW = EX_MEM_N * DATA_WIDTH;
  localparam int MEM_WB_PW = MEM_WB_N * DATA_WIDTH;

  localparam int LATCH_IDX_W = (LATCH_N   > 1) ? $clog2(LATCH_N)   : 1;
  localparam int REG_IDX_W   = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1;
  localparam int MEM_IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int LATCH_SLOTS = 2 ** LATCH_IDX_W;

  localparam logic [DATA_WIDTH-1:0] HEADER_WORD  = DATA_WIDTH'(32'hD0D0_0001);
  localparam logic [DATA_WIDTH-1:0] TRAILER_WORD = DATA_WIDTH'(32'hD0D0_FFFF);

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    LATCH,
    REG_ADDR,
    REG_PUSH,
    MEM_ADDR,
    MEM_PUSH,
    TRAIL,
    DONE
  } state_e;

  state_e                 state_q,     state_d;
  logic [LATCH_IDX_W-1:0] latch_idx_q, latch_idx_d;
  logic [REG_IDX_W-1:0]   reg_idx_q,   reg_idx_d;
  logic [MEM_IDX_W-1:0]   mem_idx_q,   mem_idx_d;

  logic [IF_ID_W-1:0]     snap_if_id_q,  snap_if_id_d;
  logic [ID_EX_W-1:0]     snap_id_ex_q,  snap_id_ex_d;
  logic [EX_MEM_W-1:0]    snap_ex_mem_q, snap_ex_mem_d;
  logic [MEM_WB_W-1:0]    snap_mem_wb_q, snap_mem_wb_d;

  logic [IF_ID_PW-1:0]    if_id_pad;
  logic [ID_EX_PW-1:0]    id_ex_pad;
  logic [EX_MEM_PW-1:0]   ex_mem_pad;
  logic [MEM_WB_PW-1:0]   mem_wb_pad;
  logic [DATA_WIDTH-1:0]  latch_words [LATCH_SLOTS];
  logic [DATA_WIDTH-1:0]  latch_word;

  logic push_state;
  logic fifo_wr;

  // Zero-extend each latch snapshot to a whole number of FIFO words.
  assign if_id_pad  = IF_ID_PW'(snap_if_id_q);
  assign id_ex_pad  = ID_EX_PW'(snap_id_ex_q);
  assign ex_mem_pad = EX_MEM_PW'(snap_ex_mem_q);
  assign mem_wb_pad = MEM_WB_PW'(snap_mem_wb_q);

  // Lay the latch words out in dump order, least-significant word first.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, otherwise unassigned paths infer latches.
    for (int i = 0; i < LATCH_SLOTS; i++) begin
      latch_words[i] = '0;
    end
    for (int i = 0; i < IF_ID_N; i++) begin
      latch_words[i] = if_id_pad[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < ID_EX_N; i++) begin
      latch_words[IF_ID_N + i] = id_ex_pad[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < EX_MEM_N; i++) begin
      latch_words[IF_ID_N + ID_EX_N + i] = ex_mem_pad[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < MEM_WB_N; i++) begin
      latch_words[IF_ID_N + ID_EX_N + EX_MEM_N + i] = mem_wb_pad[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign latch_word = latch_words[latch_idx_q];

  // FIFO write side and status outputs, all decoded from the current state.
  always_comb begin
    push_state = (state_q == HDR)      || (state_q == LATCH) ||
                 (state_q == REG_PUSH) || (state_q == MEM_PUSH) ||
                 (state_q == TRAIL);
    // Abort wins over a pending write so a cancelled dump never emits a word.
    fifo_wr      = push_state && !i_fifo_full && !i_abort;
    o_fifo_wr_en = fifo_wr;
    o_busy       = (state_q != IDLE) && (state_q != DONE);
    o_done       = (state_q == DONE) && !i_abort;
    o_reg_addr   = 5'(reg_idx_q);
    o_mem_addr   = 32'({mem_idx_q, 2'b00});

    case (state_q)
      HDR:      o_fifo_data = HEADER_WORD;
      LATCH:    o_fifo_data = latch_word;
      REG_PUSH: o_fifo_data = i_reg_content;
      MEM_PUSH: o_fifo_data = i_mem_content;
      TRAIL:    o_fifo_data = TRAILER_WORD;
      default:  o_fifo_data = '0;
    endcase
  end

  // Next-state, index and snapshot-capture logic; indices advance only on an
  // accepted write so backpressure holds the current word in place.
  always_comb begin
    state_d       = state_q;
    latch_idx_d   = latch_idx_q;
    reg_idx_d     = reg_idx_q;
    mem_idx_d     = mem_idx_q;
    snap_if_id_d  = snap_if_id_q;
    snap_id_ex_d  = snap_id_ex_q;
    snap_ex_mem_d = snap_ex_mem_q;
    snap_mem_wb_d = snap_mem_wb_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          snap_if_id_d  = i_IF_ID_latch;
          snap_id_ex_d  = i_ID_EX_latch;
          snap_ex_mem_d = i_EX_MEM_latch;
          snap_mem_wb_d = i_MEM_WB_latch;
          latch_idx_d   = '0;
          reg_idx_d     = '0;
          mem_idx_d     = '0;
          state_d       = HDR;
        end
      end
      HDR: begin
        if (fifo_wr) state_d = LATCH;
      end
      LATCH: begin
        if (fifo_wr) begin
          if (latch_idx_q == LATCH_IDX_W'(LATCH_N - 1)) begin
            latch_idx_d = '0;
            state_d     = REG_ADDR;
          end else begin
            latch_idx_d = latch_idx_q + LATCH_IDX_W'(1);
          end
        end
      end
      REG_ADDR: state_d = REG_PUSH;
      REG_PUSH: begin
        if (fifo_wr) begin
          if (reg_idx_q == REG_IDX_W'(NUM_REGS - 1)) begin
            reg_idx_d = '0;
            state_d   = MEM_ADDR;
          end else begin
            reg_idx_d = reg_idx_q + REG_IDX_W'(1);
            state_d   = REG_ADDR;
          end
        end
      end
      // Memory reads have one cycle of latency: the address is presented in
      // MEM_ADDR and the data is consumed in MEM_PUSH with the address held.
      MEM_ADDR: state_d = MEM_PUSH;
      MEM_PUSH: begin
        if (fifo_wr) begin
          if (mem_idx_q == MEM_IDX_W'(MEM_WORDS - 1)) begin
            mem_idx_d = '0;
            state_d   = TRAIL;
          end else begin
            mem_idx_d = mem_idx_q + MEM_IDX_W'(1);
            state_d   = MEM_ADDR;
          end
        end
      end
      TRAIL: begin
        if (fifo_wr) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort discards the dump from any active state.
    if (i_abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      latch_idx_d = '0;
      reg_idx_d   = '0;
      mem_idx_d   = '0;
    end
  end

  // Control state and indices, cleared by the asynchronous reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge value of its inputs.
    if (!i_reset) begin
      state_q     <= IDLE;
      latch_idx_q <= '0;
      reg_idx_q   <= '0;
      mem_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      latch_idx_q <= latch_idx_d;
      reg_idx_q   <= reg_idx_d;
      mem_idx_q   <= mem_idx_d;
    end
  end

  // Latch snapshot storage, loaded when a dump starts.
  always_ff @(posedge i_clk) begin
    // NOTE: the snapshot is a pure data store, only read after being loaded
    // on start, so it carries no reset and stays out of the reset tree.
    snap_if_id_q  <= snap_if_id_d;
    snap_id_ex_q  <= snap_id_ex_d;
    snap_ex_mem_q <= snap_ex_mem_d;
    snap_mem_wb_q <= snap_mem_wb_d;
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Self-checking bench for debug_dump_sequencer: expected dump words and their
// cycles are queued when a dump is started and compared against the words the
// FIFO write side actually produces.

module tb_debug_dump_sequencer;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic [63:0]  i_IF_ID_latch = '0;
  logic [138:0] i_ID_EX_latch = '0;
  logic [75:0]  i_EX_MEM_latch = '0;
  logic [70:0]  i_MEM_WB_latch = '0;
  logic [4:0]   o_reg_addr;
  logic [31:0]  i_reg_content;
  logic [31:0]  o_mem_addr;
  logic [31:0]  i_mem_content = '0;
  logic         o_fifo_wr_en;
  logic [31:0]  o_fifo_data;
  logic         i_fifo_full = 1'b0;
  logic         o_busy;
  logic         o_done;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected words/cycles and observed words/cycles.
  logic [31:0] exp_data_q[$];
  int          exp_cyc_q[$];
  logic [31:0] act_data_q[$];
  int          act_cyc_q[$];

  int cyc = 0;
  int c0 = 0;
  int mon_rel;
  int busy_cnt, first_busy, last_busy, done_cnt, done_cyc, full_viol;

  debug_dump_sequencer #(
    .DATA_WIDTH(32),
    .NUM_REGS  (32),
    .MEM_WORDS (32)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_IF_ID_latch (i_IF_ID_latch),
    .i_ID_EX_latch (i_ID_EX_latch),
    .i_EX_MEM_latch(i_EX_MEM_latch),
    .i_MEM_WB_latch(i_MEM_WB_latch),
    .o_reg_addr    (o_reg_addr),
    .i_reg_content (i_reg_content),
    .o_mem_addr    (o_mem_addr),
    .i_mem_content (i_mem_content),
    .o_fifo_wr_en  (o_fifo_wr_en),
    .o_fifo_data   (o_fifo_data),
    .i_fifo_full   (i_fifo_full),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial forever #5 i_clk = ~i_clk;

  initial forever begin
    @(posedge i_clk);
    cyc = cyc + 1;
  end

  // Register file model: combinational read, r[k] = 0xA000_0000 + k.
  assign i_reg_content = 32'hA000_0000 + {27'b0, o_reg_addr};

  // Data memory model: one-cycle read latency, content equals byte address.
  always @(posedge i_clk) i_mem_content <= o_mem_addr;

  // Output monitor, sampling mid-cycle on the falling edge.
  initial forever begin
    @(negedge i_clk);
    if (i_reset) begin
      mon_rel = cyc - c0 + 1;
      if (o_fifo_wr_en) begin
        act_data_q.push_back(o_fifo_data);
        act_cyc_q.push_back(mon_rel);
        if (i_fifo_full) full_viol = full_viol + 1;
      end
      if (o_busy) begin
        busy_cnt = busy_cnt + 1;
        if (first_busy < 0) first_busy = mon_rel;
        last_busy = mon_rel;
      end
      if (o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = mon_rel;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [31:0] w, input int c);
    exp_data_q.push_back(w);
    exp_cyc_q.push_back(c);
  endtask

  // Expected 79-word dump and its no-backpressure write cycles.
  task automatic push_expected(input logic [63:0] a, input logic [138:0] b,
                               input logic [75:0] c, input logic [70:0] d);
    exp_data_q.delete();
    exp_cyc_q.delete();
    push_word(32'hD0D0_0001, 1);
    push_word(a[31:0], 2);
    push_word(a[63:32], 3);
    push_word(b[31:0], 4);
    push_word(b[63:32], 5);
    push_word(b[95:64], 6);
    push_word(b[127:96], 7);
    push_word({21'b0, b[138:128]}, 8);
    push_word(c[31:0], 9);
    push_word(c[63:32], 10);
    push_word({20'b0, c[75:64]}, 11);
    push_word(d[31:0], 12);
    push_word(d[63:32], 13);
    push_word({25'b0, d[70:64]}, 14);
    for (int k = 0; k < 32; k++) push_word(32'hA000_0000 + k, 16 + 2 * k);
    for (int k = 0; k < 32; k++) push_word(4 * k, 80 + 2 * k);
    push_word(32'hD0D0_FFFF, 143);
  endtask

  task automatic random_latches();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    i_IF_ID_latch  = t[63:0];
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    i_ID_EX_latch  = t[138:0];
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    i_EX_MEM_latch = t[75:0];
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    i_MEM_WB_latch = t[70:0];
  endtask

  // Pulse i_start for one cycle; on return the bench is in dump cycle 1.
  task automatic pulse_start();
    act_data_q.delete();
    act_cyc_q.delete();
    busy_cnt = 0; first_busy = -1; last_busy = -1;
    done_cnt = 0; done_cyc = -1; full_viol = 0;
    @(posedge i_clk); #1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: o_done actual 0 required 1 within %0d cycles", name, bound);
    end
    @(posedge i_clk); #1;
  endtask

  // Pop and compare everything the scoreboard holds.
  task automatic compare_dump(input string name, input bit check_cyc);
    int idx = 0;
    checks++;
    if (act_data_q.size() != exp_data_q.size()) begin
      errors++;
      $display("FAIL %s word_count: actual %0d required %0d", name, act_data_q.size(), exp_data_q.size());
    end
    while (exp_data_q.size() > 0 && act_data_q.size() > 0) begin
      logic [31:0] e, a;
      int ec, ac;
      e = exp_data_q.pop_front();
      a = act_data_q.pop_front();
      ec = exp_cyc_q.pop_front();
      ac = act_cyc_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s word%0d: actual %h required %h", name, idx, a, e);
      end
      if (check_cyc) begin
        checks++;
        if (ac != ec) begin
          errors++;
          $display("FAIL %s word%0d_cycle: actual %0d required %0d", name, idx, ac, ec);
        end
      end
      idx++;
    end
    checks++;
    if (full_viol != 0) begin
      errors++;
      $display("FAIL %s write_while_full: actual %0d required 0", name, full_viol);
    end
    exp_data_q.delete(); exp_cyc_q.delete();
    act_data_q.delete(); act_cyc_q.delete();
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks += 6;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy: actual %b required 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset done: actual %b required 0", o_done); end
    if (o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en: actual %b required 0", o_fifo_wr_en); end
    if (o_fifo_data !== 32'h0) begin errors++; $display("FAIL reset data: actual %h required 0", o_fifo_data); end
    if (o_reg_addr !== 5'h0) begin errors++; $display("FAIL reset reg_addr: actual %h required 0", o_reg_addr); end
    if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr: actual %h required 0", o_mem_addr); end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_full_dump();
    random_latches();
    push_expected(i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch);
    pulse_start();
    wait_done("full", 300);
    checks += 5;
    if (done_cnt != 1) begin errors++; $display("FAIL full done_count: actual %0d required 1", done_cnt); end
    if (done_cyc != 144) begin errors++; $display("FAIL full done_cycle: actual %0d required 144", done_cyc); end
    if (busy_cnt != 143) begin errors++; $display("FAIL full busy_count: actual %0d required 143", busy_cnt); end
    if (first_busy != 1) begin errors++; $display("FAIL full busy_first: actual %0d required 1", first_busy); end
    if (last_busy != 143) begin errors++; $display("FAIL full busy_last: actual %0d required 143", last_busy); end
    compare_dump("full", 1'b1);
  endtask

  task automatic test_latch_snapshot();
    logic [138:0] idex;
    idex = '0;
    idex[138] = 1'b1;
    i_IF_ID_latch  = 64'h1111_2222_3333_4444;
    i_ID_EX_latch  = idex;
    i_EX_MEM_latch = {12'hABC, 32'h5555_6666, 32'h7777_8888};
    i_MEM_WB_latch = {7'h5A, 32'h9999_AAAA, 32'hBBBB_CCCC};
    push_expected(i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch);
    pulse_start();
    random_latches();
    wait_done("snapshot", 300);
    checks++;
    if (act_data_q.size() < 8) begin
      errors++;
      $display("FAIL snapshot early_words: actual %0d words required at least 8", act_data_q.size());
    end else begin
      checks += 7;
      if (act_data_q[1] !== 32'h3333_4444) begin errors++; $display("FAIL snapshot word1: actual %h required 33334444", act_data_q[1]); end
      if (act_data_q[2] !== 32'h1111_2222) begin errors++; $display("FAIL snapshot word2: actual %h required 11112222", act_data_q[2]); end
      if (act_data_q[7] !== 32'h0000_0400) begin errors++; $display("FAIL snapshot word7: actual %h required 00000400", act_data_q[7]); end
      for (int w = 3; w <= 6; w++) begin
        if (act_data_q[w] !== 32'h0) begin errors++; $display("FAIL snapshot word%0d: actual %h required 0", w, act_data_q[w]); end
      end
    end
    compare_dump("snapshot", 1'b1);
  endtask

  task automatic test_backpressure();
    random_latches();
    push_expected(i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch);
    pulse_start();
    repeat (25) begin @(posedge i_clk); #1; end
    i_fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_reg_addr !== 5'd5 || o_fifo_wr_en !== 1'b0 || o_fifo_data !== 32'hA000_0005) begin
        errors++;
        $display("FAIL bp_hold%0d: actual addr %0d wr_en %b data %h required addr 5 wr_en 0 data a0000005",
                 i, o_reg_addr, o_fifo_wr_en, o_fifo_data);
      end
      @(posedge i_clk); #1;
    end
    i_fifo_full = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_fifo_wr_en !== 1'b1 || o_fifo_data !== 32'hA000_0005) begin
      errors++;
      $display("FAIL bp_release: actual wr_en %b data %h required wr_en 1 data a0000005", o_fifo_wr_en, o_fifo_data);
    end
    wait_done("backpressure", 300);
    compare_dump("backpressure", 1'b0);
  endtask

  task automatic test_random_backpressure();
    bit seen = 1'b0;
    random_latches();
    push_expected(i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch);
    pulse_start();
    for (int i = 0; i < 2000 && !seen; i++) begin
      i_fifo_full = ($urandom_range(0, 9) < 4);
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
      @(posedge i_clk); #1;
    end
    i_fifo_full = 1'b0;
    checks += 2;
    if (!seen) begin errors++; $display("FAIL rand_bp done_timeout: o_done actual 0 required 1"); end
    if (done_cnt != 1) begin errors++; $display("FAIL rand_bp done_count: actual %0d required 1", done_cnt); end
    compare_dump("rand_bp", 1'b0);
  endtask

  task automatic test_abort();
    random_latches();
    push_expected(i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch);
    pulse_start();
    repeat (35) begin @(posedge i_clk); #1; end
    i_abort = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_fifo_wr_en !== 1'b0 || o_reg_addr !== 5'd10) begin
      errors++;
      $display("FAIL abort_cycle: actual wr_en %b addr %0d required wr_en 0 addr 10", o_fifo_wr_en, o_reg_addr);
    end
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: actual %b required 0", o_busy); end
    repeat (5) @(negedge i_clk);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: actual %0d pulses required 0", done_cnt); end
    while (exp_data_q.size() > 24) begin
      void'(exp_data_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
    compare_dump("abort", 1'b1);
    @(posedge i_clk); #1;
  endtask

  task automatic test_restart_ignored();
    random_latches();
    push_expected(i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch);
    pulse_start();
    repeat (49) begin @(posedge i_clk); #1; end
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done("restart", 300);
    checks += 2;
    if (done_cnt != 1) begin errors++; $display("FAIL restart done_count: actual %0d required 1", done_cnt); end
    if (done_cyc != 144) begin errors++; $display("FAIL restart done_cycle: actual %0d required 144", done_cyc); end
    compare_dump("restart", 1'b1);
  endtask

  task automatic test_reset_mid_dump();
    random_latches();
    pulse_start();
    repeat (49) begin @(posedge i_clk); #1; end
    #1;
    checks++;
    if (o_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rst_mid pre_wr_en: actual %b required 1", o_fifo_wr_en); end
    i_reset = 1'b0;
    #1;
    checks += 6;
    if (o_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid wr_en: actual %b required 0", o_fifo_wr_en); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: actual %b required 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL rst_mid done: actual %b required 0", o_done); end
    if (o_fifo_data !== 32'h0) begin errors++; $display("FAIL rst_mid data: actual %h required 0", o_fifo_data); end
    if (o_reg_addr !== 5'h0) begin errors++; $display("FAIL rst_mid reg_addr: actual %h required 0", o_reg_addr); end
    if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid mem_addr: actual %h required 0", o_mem_addr); end
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    random_latches();
    push_expected(i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch);
    pulse_start();
    wait_done("rst_mid", 300);
    compare_dump("rst_mid", 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_latch_snapshot();
    test_backpressure();
    test_random_backpressure();
    test_abort();
    test_restart_ignored();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
